bar0_reg_responder: RTL and testbench



---
 rtl/bar0_reg_responder_if.sv | 43 ++++
 rtl/bar0_reg_responder.sv | 160 ++++++++++++++++
 tb/tb_bar0_reg_responder.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bar0_reg_responder_if.sv
// MMIO request (CQ side) and completion (CC side) signals for the BAR0 responder.
// The master modport is the host/PCIe side; the slave modport is the responder.
interface bar0_reg_responder_if #(
  parameter int DATA_WIDTH = 256,
  parameter int BAR0_SIZE  = 16
);
  logic                    cq_valid;
  logic                    cq_is_write;
  logic                    cq_is_read;
  logic [BAR0_SIZE-1:0]    cq_reg_addr;
  logic [63:0]             cq_wr_data;
  logic [2:0]              cq_bar_id;
  logic [15:0]             cq_requester_id;
  logic [7:0]              cq_tag;
  logic [2:0]              cq_tc;
  logic [6:0]              cq_lower_addr;
  logic [10:0]             cq_dword_count;

  logic                    cc_ready;
  logic                    cc_valid;
  logic [15:0]             cc_requester_id;
  logic [7:0]              cc_tag;
  logic [2:0]              cc_tc;
  logic [6:0]              cc_lower_addr;
  logic [10:0]             cc_dword_count;
  logic [2:0]              cc_status;
  logic [DATA_WIDTH/2-1:0] cc_data;
  logic                    cc_last;

  modport master (
    output cq_valid, cq_is_write, cq_is_read, cq_reg_addr, cq_wr_data, cq_bar_id,
           cq_requester_id, cq_tag, cq_tc, cq_lower_addr, cq_dword_count, cc_ready,
    input  cc_valid, cc_requester_id, cc_tag, cc_tc, cc_lower_addr, cc_dword_count,
           cc_status, cc_data, cc_last
  );

  modport slave (
    input  cq_valid, cq_is_write, cq_is_read, cq_reg_addr, cq_wr_data, cq_bar_id,
           cq_requester_id, cq_tag, cq_tc, cq_lower_addr, cq_dword_count, cc_ready,
    output cc_valid, cc_requester_id, cc_tag, cc_tc, cc_lower_addr, cc_dword_count,
           cc_status, cc_data, cc_last
  );
endinterface

// File: rtl/bar0_reg_responder.sv
// BAR0 MMIO completer: 32-bit register file, posted writes, and a queued
// single-beat completion path for non-posted reads.
module bar0_reg_responder #(
  parameter int DATA_WIDTH = 256,
  parameter int BAR0_SIZE  = 16,
  parameter int NUM_REGS   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  bar0_reg_responder_if.slave        bus,
  output logic [31:0]                ctrl_out,
  output logic [7:0]                 drop_count
);
  localparam int AW  = BAR0_SIZE - 1;  // register index plus a carry bit so idx+1 never wraps
  localparam int RW  = $clog2(NUM_REGS);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CDW = DATA_WIDTH / 2;
  localparam logic [31:0] ID_VALUE = 32'h5645_4E54;
  localparam logic [2:0]  ST_SC    = 3'b000;
  localparam logic [2:0]  ST_UR    = 3'b001;

  typedef struct packed {
    logic [15:0] requester_id;
    logic [7:0]  tag;
    logic [2:0]  tc;
    logic [6:0]  lower_addr;
    logic [10:0] dword_count;
    logic [2:0]  status;
    logic [63:0] data;
  } cpl_t;

  typedef enum logic {IDLE, SEND} state_t;

  logic [31:0]   regs [NUM_REGS];
  logic [AW-1:0] idx_a, idx_b;
  logic          len_ok, two_dw, bar_ok, wr_en;
  logic [31:0]   rd_lo, rd_hi;
  cpl_t          rd_desc;

  assign idx_a  = {1'b0, bus.cq_reg_addr[BAR0_SIZE-1:2]};
  assign idx_b  = idx_a + AW'(1);
  assign two_dw = (bus.cq_dword_count == 11'd2);
  assign len_ok = (bus.cq_dword_count == 11'd1) || two_dw;
  assign bar_ok = (bus.cq_bar_id == 3'd0);
  assign wr_en  = bus.cq_valid && bus.cq_is_write && bar_ok && len_ok;

  function automatic logic [31:0] reg_value(input logic [AW-1:0] i);
    if (i >= AW'(NUM_REGS))         return '0;
    else if (i[RW-1:0] == '0)       return ID_VALUE;
    else if (i[RW-1:0] == RW'(3))   return {24'b0, drop_count};
    else                            return regs[i[RW-1:0]];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i != 0 && i != 3) begin
          if (idx_a == AW'(i))               regs[i] <= bus.cq_wr_data[31:0];
          else if (two_dw && idx_b == AW'(i)) regs[i] <= bus.cq_wr_data[63:32];
        end
      end
    end
  end

  assign ctrl_out = regs[2];

  // Read data comes from pre-edge register contents, so same-cycle writes are not seen.
  always_comb begin
    rd_lo                = reg_value(idx_a);
    rd_hi                = reg_value(idx_b);
    rd_desc              = '0;
    rd_desc.requester_id = bus.cq_requester_id;
    rd_desc.tag          = bus.cq_tag;
    rd_desc.tc           = bus.cq_tc;
    rd_desc.lower_addr   = bus.cq_lower_addr;
    if (bar_ok && len_ok) begin
      rd_desc.status      = ST_SC;
      rd_desc.dword_count = bus.cq_dword_count;
      rd_desc.data        = {two_dw ? rd_hi : 32'h0, rd_lo};
    end else begin
      rd_desc.status      = ST_UR;
    end
  end

  cpl_t          fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   fifo_cnt;
  logic [PW+1:0] occ;
  logic          full, empty, push, pop, rd_req;
  state_t        state, state_nxt;
  cpl_t          cpl_q;

  // The completion being presented still holds a slot until the CC side takes it.
  assign occ    = {1'b0, fifo_cnt} + {{(PW+1){1'b0}}, (state == SEND)};
  assign full   = (occ >= (PW+2)'(FIFO_DEPTH));
  assign empty  = (fifo_cnt == '0);
  assign rd_req = bus.cq_valid && bus.cq_is_read;
  assign push   = rd_req && !full;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= rd_desc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (rd_req && full && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cpl_q <= '0;
    end else begin
      state <= state_nxt;
      if (pop) cpl_q <= fifo_mem[rd_ptr];
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop       = 1'b1;
        state_nxt = SEND;
      end
      SEND: if (bus.cc_ready) begin
        if (!empty) pop = 1'b1;
        else        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.cc_valid        = (state == SEND);
  assign bus.cc_requester_id = cpl_q.requester_id;
  assign bus.cc_tag          = cpl_q.tag;
  assign bus.cc_tc           = cpl_q.tc;
  assign bus.cc_lower_addr   = cpl_q.lower_addr;
  assign bus.cc_dword_count  = cpl_q.dword_count;
  assign bus.cc_status       = cpl_q.status;
  assign bus.cc_data         = CDW'(cpl_q.data);
  assign bus.cc_last         = 1'b1;
endmodule

// File: tb/tb_bar0_reg_responder.sv
// Randomized scoreboard bench for bar0_reg_responder: a register/queue model
// predicts each completion, a separate monitor pops and compares.
module tb_bar0_reg_responder;
  localparam int DW = 256, BS = 16, NR = 16, FD = 4;
  localparam logic [31:0] ID_VALUE = 32'h5645_4E54;

  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] ctrl_out;
  logic [7:0]  drop_count;
  int total = 0, bad = 0;

  bar0_reg_responder_if #(.DATA_WIDTH(DW), .BAR0_SIZE(BS)) bus();

  bar0_reg_responder #(.DATA_WIDTH(DW), .BAR0_SIZE(BS), .NUM_REGS(NR), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .bus(bus), .ctrl_out(ctrl_out), .drop_count(drop_count));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] rid; logic [7:0] tag; logic [2:0] tc; logic [6:0] la;
    logic [10:0] dwc; logic [2:0] st; logic [DW/2-1:0] data; logic last;
  } cpl_t;

  cpl_t expq[$];
  logic [31:0] m_reg [NR];
  int m_drop = 0, outstanding = 0;
  int rdy_mode = 0;  // 0 ready, 1 stalled, 2 toggle, 3 random

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mget(input int i);
    if (i == 0) return ID_VALUE;
    if (i == 3) return {24'b0, 8'(m_drop)};
    if (i < NR) return m_reg[i];
    return 32'h0;
  endfunction

  function automatic void mset(input int i, input logic [31:0] v);
    if (i < NR && i != 0 && i != 3) m_reg[i] = v;
  endfunction

  function automatic cpl_t model_read();
    cpl_t c = '0;
    int i = int'(bus.cq_reg_addr) >> 2;
    int n = int'(bus.cq_dword_count);
    c.rid = bus.cq_requester_id; c.tag = bus.cq_tag; c.tc = bus.cq_tc; c.la = bus.cq_lower_addr;
    c.last = 1'b1;
    if (bus.cq_bar_id == 0 && (n == 1 || n == 2)) begin
      c.st = 3'b000; c.dwc = 11'(n);
      c.data[31:0] = mget(i);
      if (n == 2) c.data[63:32] = mget(i + 1);
    end else c.st = 3'b001;
    return c;
  endfunction

  // Reference model: evaluated mid-cycle when inputs and cc_* are stable for the next edge.
  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
      for (int i = 0; i < NR; i++) m_reg[i] = '0;
      m_drop = 0; outstanding = 0;
    end else begin
      if (bus.cq_valid && bus.cq_is_read) begin
        if (outstanding < FD) begin
          expq.push_back(model_read());
          outstanding++;
        end else if (m_drop < 255) m_drop++;
      end
      if (bus.cq_valid && bus.cq_is_write && bus.cq_bar_id == 0 &&
          (bus.cq_dword_count == 1 || bus.cq_dword_count == 2)) begin
        mset(int'(bus.cq_reg_addr) >> 2, bus.cq_wr_data[31:0]);
        if (bus.cq_dword_count == 2) mset((int'(bus.cq_reg_addr) >> 2) + 1, bus.cq_wr_data[63:32]);
      end
      if (bus.cc_valid && bus.cc_ready) outstanding--;
    end
  end

  cpl_t prev_c;
  bit   stalled = 0;
  always @(negedge clk) begin
    cpl_t act, exp;
    if (rst || !bus.cc_valid) stalled = 0;
    else begin
      act = {bus.cc_requester_id, bus.cc_tag, bus.cc_tc, bus.cc_lower_addr,
             bus.cc_dword_count, bus.cc_status, bus.cc_data, bus.cc_last};
      if (stalled) begin
        total++;
        if (act !== prev_c) begin
          bad++;
          $display("FAIL stall_hold: tag %h st %h data %h expected tag %h st %h data %h",
                   act.tag, act.st, act.data[63:0], prev_c.tag, prev_c.st, prev_c.data[63:0]);
        end
      end
      if (bus.cc_ready) begin
        total++;
        if (expq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_cpl: tag %h with nothing expected", act.tag);
        end else begin
          exp = expq.pop_front();
          if (act !== exp) begin
            bad++;
            $display("FAIL cpl: rid %h tag %h tc %h la %h dwc %h st %h data %h last %b expected rid %h tag %h tc %h la %h dwc %h st %h data %h last %b",
                     act.rid, act.tag, act.tc, act.la, act.dwc, act.st, act.data, act.last,
                     exp.rid, exp.tag, exp.tc, exp.la, exp.dwc, exp.st, exp.data, exp.last);
          end
        end
      end
      stalled = !bus.cc_ready;
      prev_c  = act;
    end
  end

  initial begin
    bus.cc_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: bus.cc_ready = 1'b1;
        1: bus.cc_ready = 1'b0;
        2: bus.cc_ready = ~bus.cc_ready;
        default: bus.cc_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic issue(input bit wr, input logic [15:0] addr, input logic [63:0] wd,
                       input logic [2:0] bar, input logic [10:0] dwc, input logic [7:0] tag);
    bus.cq_valid = 1'b1; bus.cq_is_write = wr; bus.cq_is_read = !wr;
    bus.cq_reg_addr = addr; bus.cq_wr_data = wd; bus.cq_bar_id = bar;
    bus.cq_dword_count = dwc; bus.cq_tag = tag;
    bus.cq_requester_id = 16'($urandom); bus.cq_tc = 3'($urandom); bus.cq_lower_addr = 7'($urandom);
    @(posedge clk); #1;
    bus.cq_valid = 1'b0; bus.cq_is_write = 1'b0; bus.cq_is_read = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (expq.size() == 0 && !bus.cc_valid) done = 1;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d completions still pending, expected 0", expq.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bus.cq_valid = 0; bus.cq_is_write = 0; bus.cq_is_read = 0; bus.cq_reg_addr = '0;
    bus.cq_wr_data = '0; bus.cq_bar_id = '0; bus.cq_requester_id = '0; bus.cq_tag = '0;
    bus.cq_tc = '0; bus.cq_lower_addr = '0; bus.cq_dword_count = '0;
    repeat (3) @(negedge clk);
    check("rst_cc_valid", 64'(bus.cc_valid), 64'd0);
    check("rst_cc_last", 64'(bus.cc_last), 64'd1);
    check("rst_cc_tag", 64'(bus.cc_tag), 64'd0);
    check("rst_ctrl_out", 64'(ctrl_out), 64'd0);
    check("rst_drop_count", 64'(drop_count), 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    idle(2);

    // ID read and its two-cycle latency
    issue(0, 16'h0, '0, 3'd0, 11'd1, 8'h11);
    @(negedge clk); check("lat_n1_valid", 64'(bus.cc_valid), 64'd0);
    @(negedge clk); check("lat_n2_valid", 64'(bus.cc_valid), 64'd1);
    check("id_data", 64'(bus.cc_data[31:0]), 64'h5645_4E54);
    check("id_tag", 64'(bus.cc_tag), 64'h11);
    @(posedge clk); #1;
    wait_drain();

    issue(1, 16'h8, 64'hA5A5_0001, 3'd0, 11'd1, 8'h0);
    check("ctrl_out_write", 64'(ctrl_out), 64'hA5A5_0001);
    issue(1, 16'h10, 64'h2222_2222_1111_1111, 3'd0, 11'd2, 8'h0);
    issue(0, 16'h10, '0, 3'd0, 11'd2, 8'h21);
    issue(0, 16'h4, '0, 3'd1, 11'd1, 8'h22);
    issue(0, 16'h4, '0, 3'd0, 11'd3, 8'h23);
    issue(1, 16'h0, 64'hDEAD_BEEF, 3'd0, 11'd1, 8'h0);
    issue(0, 16'h0, '0, 3'd0, 11'd1, 8'h24);
    issue(1, 16'h3C, 64'h7777_7777_6666_6666, 3'd0, 11'd2, 8'h0);
    issue(0, 16'h3C, '0, 3'd0, 11'd2, 8'h25);
    wait_drain();

    // six reads while stalled: four fit, two are dropped
    rdy_mode = 1; idle(1);
    for (int t = 1; t <= 6; t++) issue(0, 16'h4, '0, 3'd0, 11'd1, 8'(t));
    check("drop_count_2", 64'(drop_count), 64'd2);
    rdy_mode = 0;
    wait_drain();
    issue(0, 16'hC, '0, 3'd0, 11'd1, 8'h30);
    wait_drain();

    rdy_mode = 2;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) != 0) issue(0, 16'($urandom_range(0, 17) * 4), '0, 3'd0,
                                           11'($urandom_range(1, 2)), 8'(i + 64));
      else idle(1);
    end
    rdy_mode = 0;
    wait_drain();

    rdy_mode = 3;
    for (int i = 0; i < 400; i++) begin
      int op = $urandom_range(0, 9);
      logic [15:0] a = ($urandom_range(0, 15) == 0) ? 16'($urandom) : 16'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
      logic [10:0] n = 11'($urandom_range(0, 7) < 6 ? $urandom_range(1, 2) : $urandom_range(0, 4));
      logic [2:0]  b = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'd0;
      if (op < 4)      issue(0, a, '0, b, n, 8'(i));
      else if (op < 7) issue(1, a, {$urandom, $urandom}, b, n, 8'(i));
      else             idle(1);
    end
    rdy_mode = 0;
    wait_drain();
    check("rand_drop_count", 64'(drop_count), 64'(m_drop));
    check("rand_ctrl_out", 64'(ctrl_out), 64'(m_reg[2]));

    // reset while a completion is presented with more queued behind it
    issue(1, 16'h4, 64'h1234_5678, 3'd0, 11'd1, 8'h0);
    rdy_mode = 1; idle(1);
    for (int t = 0; t < 4; t++) issue(0, 16'h4, '0, 3'd0, 11'd1, 8'(8'h80 + t));
    @(negedge clk); check("pre_rst_valid", 64'(bus.cc_valid), 64'd1);
    @(posedge clk); #1; rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(bus.cc_valid), 64'd0);
    check("async_rst_tag", 64'(bus.cc_tag), 64'd0);
    check("async_rst_drop", 64'(drop_count), 64'd0);
    idle(2);
    rst = 1'b0; rdy_mode = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); check("post_rst_quiet", 64'(bus.cc_valid), 64'd0);
    end
    @(posedge clk); #1;
    issue(0, 16'h4, '0, 3'd0, 11'd1, 8'h99);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
